// File: rtl/dsb_tm_engine.sv
// Time-multiplexed discrete simulated-bifurcation solver: N_SPINS spins share one
// semi-implicit update datapath, with coupling forces fetched over a req/valid handshake.
module dsb_tm_engine #(
  parameter int N_SPINS  = 8,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int DT_SHIFT = 2,
  parameter int STEPS    = 100,
  parameter logic [WIDTH-1:0] A_INC = WIDTH'(16'h0004),
  localparam int IW = (N_SPINS > 1) ? $clog2(N_SPINS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    cf_req,
  output logic [IW-1:0]           cf_idx,
  input  logic                    cf_valid,
  input  logic signed [WIDTH-1:0] cf_data,
  output logic [N_SPINS-1:0]      sign_vec,
  output logic signed [WIDTH-1:0] a_t,
  input  logic [IW-1:0]           rd_idx,
  output logic signed [WIDTH-1:0] rd_x,
  output logic signed [WIDTH-1:0] rd_y
);

  localparam int EW = WIDTH + 2;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  typedef enum logic [2:0] {IDLE, REQ, UPD, STEP_END, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] x_mem [N_SPINS];
  logic signed [WIDTH-1:0] y_mem [N_SPINS];
  logic [IW-1:0]           spin;
  logic [SW-1:0]           step;
  logic signed [WIDTH-1:0] h_reg;

  logic signed [WIDTH-1:0]   x_cur, y_cur, y_upd, x_upd, x_wr, y_wr, a_next;
  logic signed [WIDTH:0]     coef;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [EW-1:0]      p_e, h_ext, x_ext, y_ext, diff_e, diff_sh;
  logic signed [EW-1:0]      y_sum, y_upd_ext, y_step, x_sum;
  logic [WIDTH:0]            a_sum;

  // Clamp a widened sum back into the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v[EW-1:WIDTH-1] == {(EW-WIDTH+1){v[EW-1]}})
      return v[WIDTH-1:0];
    else if (v[EW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Shared update datapath; every shift goes through a signed variable so >>> floors.
  always_comb begin
    x_cur     = x_mem[spin];
    y_cur     = y_mem[spin];
    coef      = {1'b0, ONE} - {1'b0, a_t};
    prod      = {{(WIDTH-1){coef[WIDTH]}}, coef} * {{WIDTH{x_cur[WIDTH-1]}}, x_cur};
    p_e       = EW'(prod >>> FRAC);
    h_ext     = {{2{h_reg[WIDTH-1]}}, h_reg};
    x_ext     = {{2{x_cur[WIDTH-1]}}, x_cur};
    y_ext     = {{2{y_cur[WIDTH-1]}}, y_cur};
    diff_e    = h_ext - p_e;
    diff_sh   = diff_e >>> DT_SHIFT;
    y_sum     = y_ext + diff_sh;
    y_upd     = sat(y_sum);
    y_upd_ext = {{2{y_upd[WIDTH-1]}}, y_upd};
    y_step    = y_upd_ext >>> DT_SHIFT;
    x_sum     = x_ext + y_step;
    x_upd     = sat(x_sum);
    x_wr      = x_upd;
    y_wr      = y_upd;
    if (x_upd > ONE) begin
      x_wr = ONE;
      y_wr = '0;
    end else if (x_upd < NEG_ONE) begin
      x_wr = NEG_ONE;
      y_wr = '0;
    end
    a_sum  = {1'b0, a_t} + {1'b0, A_INC};
    a_next = (a_sum > {1'b0, ONE}) ? ONE : a_sum[WIDTH-1:0];
  end

  assign cf_idx = spin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cf_req   <= 1'b0;
      spin     <= '0;
      step     <= '0;
      a_t      <= '0;
      sign_vec <= '0;
      h_reg    <= '0;
      for (int i = 0; i < N_SPINS; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            spin     <= '0;
            step     <= '0;
            a_t      <= '0;
            sign_vec <= '0;
            for (int i = 0; i < N_SPINS; i++) begin
              x_mem[i] <= '0;
              y_mem[i] <= '0;
            end
            busy   <= 1'b1;
            cf_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (cf_valid) begin
            h_reg  <= cf_data;
            cf_req <= 1'b0;
            state  <= UPD;
          end
        end
        UPD: begin
          x_mem[spin] <= x_wr;
          y_mem[spin] <= y_wr;
          if (spin == IW'(N_SPINS - 1)) begin
            state <= STEP_END;
          end else begin
            spin   <= spin + IW'(1);
            cf_req <= 1'b1;
            state  <= REQ;
          end
        end
        STEP_END: begin
          // Snapshot signs once per step so the network sees Jacobi-style states.
          for (int i = 0; i < N_SPINS; i++)
            sign_vec[i] <= x_mem[i][WIDTH-1];
          a_t  <= a_next;
          spin <= '0;
          if (step == SW'(STEPS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            step   <= step + SW'(1);
            cf_req <= 1'b1;
            state  <= REQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if (int'(rd_idx) < N_SPINS) begin
      rd_x <= x_mem[rd_idx];
      rd_y <= y_mem[rd_idx];
    end else begin
      rd_x <= '0;
      rd_y <= '0;
    end
  end

endmodule

// File: tb/tb_dsb_tm_engine.sv
// Self-checking bench for dsb_tm_engine: hand-derived step tables, timing sequences,
// and randomized runs checked against an integer-arithmetic reference model.
module tb_dsb_tm_engine;

  localparam int N       = 4;
  localparam int STEPS_P = 4;
  localparam int NREQ    = N * STEPS_P;
  localparam int ONE_I   = 256;
  localparam int DT_I    = 4;
  localparam int AINC_I  = 64;
  localparam int CPS     = 2 * N + 1;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, cf_req, cf_valid;
  logic [1:0]  cf_idx, rd_idx;
  logic [15:0] cf_data, a_t, rd_x, rd_y;
  logic [3:0]  sign_vec;

  dsb_tm_engine #(
    .N_SPINS(N), .WIDTH(16), .FRAC(8), .DT_SHIFT(2), .STEPS(STEPS_P), .A_INC(16'h0040)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cf_req(cf_req), .cf_idx(cf_idx), .cf_valid(cf_valid), .cf_data(cf_data),
    .sign_vec(sign_vec), .a_t(a_t), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] h;
    int          step;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] a;
    logic        s0;
  } vec_t;

  int          checks = 0, errors = 0;
  int          edge_cnt = 0, run_base = 0;
  logic [15:0] h_tab [NREQ];
  int          hs_count = 0, total_wait = 0, fixed_wait = 0;
  bit          rand_wait = 0, noise = 0;
  int          m_x [N];
  int          m_y [N];
  int          m_a;
  logic [3:0]  m_sign;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] u16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

  function automatic int fdiv(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] randH();
    case ($urandom_range(0, 3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'($urandom);
      default: return 16'(int'($urandom_range(0, 2047)) - 1024);
    endcase
  endfunction

  // Reference: whole run computed step by step with plain integer floor arithmetic.
  task automatic runModel();
    int h, p, yn, xn;
    m_a = 0;
    m_sign = '0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
    for (int s = 0; s < STEPS_P; s++) begin
      for (int i = 0; i < N; i++) begin
        h  = int'($signed(h_tab[s * N + i]));
        p  = fdiv((ONE_I - m_a) * m_x[i], ONE_I);
        yn = clamp16(m_y[i] + fdiv(h - p, DT_I));
        xn = clamp16(m_x[i] + fdiv(yn, DT_I));
        if (xn > ONE_I) begin
          xn = ONE_I;
          yn = 0;
        end else if (xn < -ONE_I) begin
          xn = -ONE_I;
          yn = 0;
        end
        m_x[i] = xn;
        m_y[i] = yn;
      end
      for (int i = 0; i < N; i++) m_sign[i] = (m_x[i] < 0);
      m_a = (m_a + AINC_I > ONE_I) ? ONE_I : m_a + AINC_I;
    end
  endtask

  // Coupling network stand-in: optional wait states, optional cf_valid noise while idle.
  initial begin
    bit in_req;
    int wait_cnt, cur_wait;
    in_req = 0; wait_cnt = 0; cur_wait = 0;
    cf_valid = 1'b0;
    cf_data  = '0;
    forever begin
      @(negedge clk);
      if (rst || !cf_req) begin
        in_req   = 0;
        cf_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cf_data  = 16'($urandom);
      end else begin
        if (!in_req) begin
          in_req     = 1;
          wait_cnt   = 0;
          cur_wait   = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
          total_wait += cur_wait;
        end
        checkOutput("cf_idx_stable", 32'(cf_idx), 32'(hs_count % N));
        if (wait_cnt >= cur_wait) begin
          cf_valid = 1'b1;
          cf_data  = (hs_count < NREQ) ? h_tab[hs_count] : 16'h0;
          hs_count++;
        end else begin
          cf_valid = 1'b0;
          cf_data  = 16'($urandom);
          wait_cnt++;
        end
      end
    end
  end

  task automatic applyStimulus();
    hs_count   = 0;
    total_wait = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_base = edge_cnt;
  endtask

  task automatic waitUntilCycle(input int c);
    while (edge_cnt < run_base + c - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone(input string tag);
    bit found;
    int cyc;
    found = 0;
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        found = 1;
        cyc = edge_cnt - run_base + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(1 + STEPS_P * CPS + total_wait));
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_cf_req"}, 32'(cf_req), 0);
    checkOutput({tag, "_cf_idx"}, 32'(cf_idx), 0);
    checkOutput({tag, "_sign_vec"}, 32'(sign_vec), 0);
    checkOutput({tag, "_a_t"}, u16(a_t), 0);
    checkOutput({tag, "_rd_x"}, u16(rd_x), 0);
    checkOutput({tag, "_rd_y"}, u16(rd_y), 0);
  endtask

  task automatic compareModel(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_idx = 2'(i);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_x%0d", tag, i), u16(rd_x), u16(16'(m_x[i])));
      checkOutput($sformatf("%s_y%0d", tag, i), u16(rd_y), u16(16'(m_y[i])));
    end
    checkOutput({tag, "_sign_vec"}, 32'(sign_vec), 32'(m_sign));
    checkOutput({tag, "_a_t"}, u16(a_t), u16(16'(m_a)));
    rd_idx = 2'd0;
  endtask

  task automatic modelRun(input string tag, input bit pulse_start);
    runModel();
    applyStimulus();
    if (pulse_start) begin
      waitUntilCycle(10);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitDone(tag);
    compareModel(tag);
  endtask

  initial begin
    vec_t tv [8];
    bit saw_done, saw_busy;
    tv[0] = '{16'h0400, 1, 16'h0040, 16'h0100, 16'h0040, 1'b0};
    tv[1] = '{16'h0400, 2, 16'h00BD, 16'h01F4, 16'h0080, 1'b0};
    tv[2] = '{16'h0400, 3, 16'h0100, 16'h0000, 16'h00C0, 1'b0};
    tv[3] = '{16'h0400, 4, 16'h0100, 16'h0000, 16'h0100, 1'b0};
    tv[4] = '{16'hFC00, 1, 16'hFFC0, 16'hFF00, 16'h0040, 1'b1};
    tv[5] = '{16'hFC00, 2, 16'hFF43, 16'hFE0C, 16'h0080, 1'b1};
    tv[6] = '{16'hFC00, 3, 16'hFF00, 16'h0000, 16'h00C0, 1'b1};
    tv[7] = '{16'hFC00, 4, 16'hFF00, 16'h0000, 16'h0100, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    rd_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) h_tab[k] = '0;

    // Reset held three cycles with a start pulse inside it: no run may begin.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkIdle("reset");
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_start_ignored_busy", 32'(busy), 0);

    // First update and read-during-write latency.
    for (int k = 0; k < NREQ; k++) h_tab[k] = 16'h0180;
    applyStimulus();
    checkOutput("first_cf_req", 32'(cf_req), 1);
    checkOutput("first_busy", 32'(busy), 1);
    waitUntilCycle(3);
    checkOutput("first_rd_x_old", u16(rd_x), 0);
    waitUntilCycle(4);
    checkOutput("first_rd_x", u16(rd_x), 32'h0018);
    checkOutput("first_rd_y", u16(rd_y), 32'h0060);

    // Reset mid-run aborts without done.
    waitUntilCycle(15);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdle("midreset");
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    saw_busy = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    checkOutput("midreset_no_done", 32'(saw_done), 0);
    checkOutput("midreset_no_busy", 32'(saw_busy), 0);

    // Wall clipping and negative drive, sampled right after each STEP_END.
    for (int r = 0; r < 8; r++) begin
      if (tv[r].step == 1) begin
        for (int k = 0; k < NREQ; k++) h_tab[k] = tv[r].h;
        applyStimulus();
      end
      waitUntilCycle(CPS * tv[r].step + 1);
      checkOutput($sformatf("tbl%0d_x0", r), u16(rd_x), u16(tv[r].x0));
      checkOutput($sformatf("tbl%0d_y0", r), u16(rd_y), u16(tv[r].y0));
      checkOutput($sformatf("tbl%0d_a_t", r), u16(a_t), u16(tv[r].a));
      checkOutput($sformatf("tbl%0d_sign0", r), 32'(sign_vec[0]), 32'(tv[r].s0));
      checkOutput($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tv[r].step < STEPS_P));
      if (tv[r].step == STEPS_P) waitDone($sformatf("tbl%0d", r));
    end

    // Zero-wait run with a stray start mid-run, then a second run from cleared state.
    for (int k = 0; k < NREQ; k++) h_tab[k] = randH();
    modelRun("zw_midstart", 1'b1);
    for (int k = 0; k < NREQ; k++) h_tab[k] = randH();
    modelRun("zw_second", 1'b0);

    // Backpressure: three wait cycles per request.
    fixed_wait = 3;
    for (int k = 0; k < NREQ; k++) h_tab[k] = randH();
    modelRun("bp3", 1'b0);
    fixed_wait = 0;

    // Large positive drive must saturate rather than wrap.
    for (int k = 0; k < NREQ; k++) h_tab[k] = 16'h7FFF;
    modelRun("sat", 1'b0);

    // Randomized runs: random wait states and cf_valid noise outside requests.
    rand_wait = 1;
    noise = 1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NREQ; k++) h_tab[k] = randH();
      modelRun($sformatf("rnd%0d", r), 1'b0);
    end
    rand_wait = 0;
    noise = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsb_tm_engine.md
# dsb_tm_engine

Time-multiplexed discrete simulated-bifurcation (dSB) solver that generalises the single-spin `dsb_pe` to `N_SPINS` spins sharing one update datapath. It holds per-spin position `x` and momentum `y` in Q(`WIDTH`-`FRAC`).`FRAC` registers and ramps the bifurcation parameter a(t) internally. It fetches each spin's coupling force from the external coupling network over a req/valid handshake, and publishes a frozen sign vector that the network consumes.

## Interface
- `N_SPINS`, 8: number of spins; index width `IW` = max(1, clog2(`N_SPINS`)).
- `WIDTH`, 16: signed fixed-point width of x, y, a, h.
- `FRAC`, 8: fractional bits; ONE = 1<<`FRAC`.
- `DT_SHIFT`, 2: time step dt = 2^-`DT_SHIFT`.
- `STEPS`, 100: integration steps per run.
- `A_INC`, 16'h0004: a(t) increment per step.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin run; sampled only in IDLE.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.
- `cf_req`  out  1  coupling request.
- `cf_idx`  out  IW  spin index being requested.
- `cf_valid`  in  1  coupling data valid.
- `cf_data`  in  WIDTH  signed coupling force h for `cf_idx`.
- `sign_vec`  out  N_SPINS  snapshot of sign(x_i); bit = MSB of x_i (1 = negative).
- `a_t`  out  WIDTH  current a(t).
- `rd_idx`  in  IW  debug read index.
- `rd_x`, `rd_y`  out  WIDTH  x/y of `rd_idx`, registered with 1-cycle latency.

## Operation
- States: IDLE, REQ, UPD, STEP_END, DONE.
- IDLE, `start`=1: clear all x, y, `sign_vec`, a_t, step and spin counters; go to REQ.
- REQ: `cf_req`=1, `cf_idx`=spin. On `cf_valid`=1, latch `cf_data` and go to UPD. This includes `cf_valid` in the same cycle `cf_req` first rises.
- UPD: semi-implicit update of spin i, with arithmetic >>> (floor):
  - p = ((ONE - a_t) * x_i) >>> FRAC (2·WIDTH product).
  - y' = sat(y_i + ((h - p) >>> DT_SHIFT)).
  - x' = sat(x_i + (y' >>> DT_SHIFT)).
  - Intermediate sums use WIDTH+2 bits; sat clamps to the signed WIDTH range.
  - Wall: if x' > ONE, write x = ONE and y = 0. If x' < -ONE, write x = -ONE and y = 0. Exactly ±ONE is kept as-is with y'.
  - Last spin: go to STEP_END. Otherwise spin++ and go to REQ.
- STEP_END:
  - `sign_vec` ← MSB of every x.
  - a_t ← min(a_t + A_INC, ONE).
  - spin ← 0.
  - If step == STEPS-1, go to DONE. Otherwise step++ and go to REQ.
- DONE: `done`=1 for one cycle, then go to IDLE. x, y, `sign_vec` and a_t are retained until the next `start`.
- `sign_vec` is constant for a whole step, so the coupling network sees synchronous (Jacobi) spin states.
- `start` is ignored outside IDLE. `cf_valid` is ignored when `cf_req`=0.

## Timing
- Reset: all x, y, `sign_vec`, a_t, `rd_x`, `rd_y` = 0; `busy`, `done`, `cf_req`, `cf_idx` = 0; state = IDLE. Reset mid-run aborts the run immediately; no `done` is issued.
- `busy` = 1 in REQ, UPD and STEP_END; 0 in IDLE and DONE.
- `cf_idx` is stable while `cf_req` is high. Each wait cycle (no `cf_valid`) adds one cycle of latency with no state change.
- Zero-wait cost per step: 2·N_SPINS + 1 cycles.
- Zero-wait run: `start` sampled at cycle 0 → `done` at cycle 1 + STEPS·(2·N_SPINS+1).
- `rd_x` and `rd_y` reflect array contents as of the previous edge. A read of a spin being written in UPD returns the old value.

## Test plan
Common setup: WIDTH=16, FRAC=8, DT_SHIFT=2, N_SPINS=4, STEPS=4, A_INC=16'h0040.
- Reset/idle: hold `rst` for 3 cycles, then idle → all outputs 0. `start` pulsed with `rst`=1 → no run.
- First update: `cf_data`=16'h0180, zero-wait → after spin 0 UPD, `rd_x`=16'h0018 and `rd_y`=16'h0060.
- Wall clip, `cf_data`=16'h0400 constant for spin 0:
  - After each step, x0 = 0x0040, 0x00BD, then clipped to 0x0100 with y0=0 at step 3.
  - `sign_vec[0]`=0 throughout.
  - a_t = 0x0040, 0x0080, 0x00C0, 0x0100.
- Negative drive, `cf_data`=16'hFC00 → x0 reaches 16'hFF00 at step 3 with y0=0; `sign_vec[0]`=1 from the first STEP_END. Separately, `cf_data`=16'h7FFF must saturate y and never wrap.
- Backpressure: `cf_valid` delayed 3 cycles per request → `cf_req` and `cf_idx` held stable, no array writes during the wait, `done` at cycle 1 + 4·(4·5+1) = 85.
- Zero-wait run length: `done` at cycle 37. `start` asserted mid-run is ignored. A second run after DONE restarts from cleared state. `rst` asserted mid-run returns to IDLE with all outputs 0 and no `done`.
